load_unit: RTL
==============

# load_unit

Memory-access stage for the core's load instructions: accepts one decoded load (address, funct3, destination register) from execute, fetches the covering 32-bit words over an AXI4-Lite read channel, and returns a sign- or zero-extended XLEN result for register writeback. It sits between execute and the register file on the SoC data bus. It handles loads that cross 32-bit word boundaries by issuing sequential single-word reads.

## Interface
- `ADDR_WIDTH`, default `XLEN: AXI read address width.
- `clk`  in  1  system clock; all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  load request present.
- `req_ready`  out  1  unit idle and able to accept; 0 while `rst` is high.
- `req_addr`  in  `XLEN  byte address (any alignment).
- `req_funct3`  in  3  000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU, 111 illegal.
- `req_rd`  in  5  destination register.
- `arvalid` / `arready`  out / in  1  AXI4-Lite read-address handshake.
- `araddr`  out  ADDR_WIDTH  word-aligned address (bits [1:0] = 0).
- `arprot`  out  3  constant 3'b000.
- `rvalid` / `rready`  in / out  1  AXI4-Lite read-data handshake.
- `rdata`  in  32  read data, little-endian.
- `rresp`  in  2  response; anything other than 2'b00 is a fault.
- `wb_valid`  out  1  one-cycle pulse: result ready.
- `wb_rd`  out  5  destination register for this result.
- `wb_data`  out  `XLEN  extended load result; 0 on fault.
- `wb_fault`  out  1  qualifies `wb_valid`: access fault or illegal funct3.

## Operation
- Size is 1, 2, 4 or 8 bytes, taken from funct3[1:0]. Signed when funct3[2] = 0.
- Offset `off` = `req_addr[1:0]`. Beats `n = ((off + size - 1) >> 2) + 1`, giving a range of 1 to 3. Beat k address = `{req_addr[ADDR_WIDTH-1:2], 2'b00} + 4*k`, wrapping modulo 2^ADDR_WIDTH.
- States:
  - IDLE: `req_ready` = 1. On `req_valid`, latch addr/funct3/rd and clear the 96-bit beat buffer.
    - funct3 = 111 goes to DONE with fault, with no bus traffic.
    - Any other funct3 goes to ADDR.
  - ADDR: `arvalid` = 1 with `araddr` for the current beat. Hold both stable until `arready`, then go to DATA.
  - DATA: `rready` = 1. On `rvalid`, store `rdata` into buffer bits [32k+31:32k].
    - `rresp` ≠ 0: set fault and go to DONE. Remaining beats are not issued.
    - Last beat: go to DONE.
    - Otherwise: k++ and go to ADDR.
  - DONE: `wb_valid` = 1 for one cycle, then go to IDLE.
- Result = (buffer >> 8*off) truncated to size bytes, then sign- or zero-extended to XLEN. LD has no extension. On fault, `wb_data` = 0.
- At most one AR outstanding; a new AR is never issued before the previous R completes.
- Reset in any state: go to IDLE immediately and drop `arvalid`/`rready`. Any in-flight R is discarded; the interconnect is reset with the core.

## Timing
- Reset values: `req_ready`, `arvalid`, `rready`, `wb_valid`, `wb_fault` = 0; `araddr`, `wb_rd`, `wb_data` = 0.
- Request accepted at cycle T. `arvalid` rises at T+1.
- Zero-wait slave (arready=1, rvalid on the cycle after AR): 1 beat gives `wb_valid` at T+3; each extra beat adds 2 cycles, so 3 beats give T+7.
- Illegal funct3 gives `wb_valid` at T+1.
- `req_ready` is 0 from T+1 until the cycle after `wb_valid`. Back-to-back loads are therefore at minimum 4 cycles apart.
- `arvalid` never drops without `arready`. `rready` is never asserted outside DATA.

## Structure
- The shared core package holds:
  - the `load_funct3_t` enum (encodings above);
  - the size-decode function;
  - the `load_state_t` enum {IDLE, ADDR, DATA, DONE};
  - the `AXI_RESP_OKAY` constant.
- One sub-module, `load_extract`: a purely combinational block taking buffer, off and funct3 and producing the XLEN result. It is reusable by a later store/AMO path.

## Test plan
Memory used by all scenarios: word 0x2C = 0x8A8FC3C7, 0x30 = 0x017F423C, 0x34 = 0x66778899.

- LB 0x2C → one AR @0x2C; `wb_data` = 0xFFFFFFFFFFFFFFC7; LBU 0x2F → 0x8A.
- LD 0x30 → ARs 0x30 then 0x34; `wb_data` = 0x66778899017F423C. LWU 0x2C → 0x8A8FC3C7 with upper bits zero.
- Crossing loads:
  - LH 0x2F → ARs 0x2C, 0x30; `wb_data` = 0x3C8A.
  - LD 0x2D → ARs 0x2C, 0x30, 0x34; `wb_data` = 0x99017F423C8A8FC3.
- funct3 = 111 → no AR; `wb_valid` and `wb_fault` at T+1; `wb_data` = 0.
- Faults and backpressure:
  - `rresp` = SLVERR on beat 0 of LD 0x30 → no second AR; `wb_fault` = 1; `wb_data` = 0.
  - `arready` held low 5 cycles → `arvalid`/`araddr` stable throughout.
- `rst` pulsed while in DATA → next cycle in IDLE with all outputs at reset values. The following LB 0x2C completes correctly.

Source files
------------

// File: rtl/load_pkg.sv
// Shared definitions for the load path: funct3 encodings, FSM states,
// AXI response codes and the access-size decode.
package load_pkg;

  localparam int XLEN = 64;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  typedef enum logic [2:0] {
    F3_LB      = 3'b000,
    F3_LH      = 3'b001,
    F3_LW      = 3'b010,
    F3_LD      = 3'b011,
    F3_LBU     = 3'b100,
    F3_LHU     = 3'b101,
    F3_LWU     = 3'b110,
    F3_ILLEGAL = 3'b111
  } load_funct3_t;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    DONE
  } load_state_t;

  // Access size in bytes (1, 2, 4 or 8) from the low two funct3 bits.
  function automatic logic [3:0] load_size(input logic [2:0] f3);
    return 4'd1 << f3[1:0];
  endfunction

  // Index of the last 32-bit beat touched by an access: 0, 1 or 2.
  function automatic logic [1:0] load_last_beat(input logic [1:0] off, input logic [2:0] f3);
    return 2'(({2'b00, off} + load_size(f3) - 4'd1) >> 2);
  endfunction

endpackage

// File: rtl/load_extract.sv
// Combinational byte extraction: picks size bytes starting at off from the
// up-to-three-beat buffer and sign- or zero-extends them to XLEN.
module load_extract
  import load_pkg::*;
(
  input  logic [95:0]     buf_i,
  input  logic [1:0]      off_i,
  input  logic [2:0]      funct3_i,
  output logic [XLEN-1:0] result_o
);

  logic [63:0] win;
  logic        unused_top;

  // The highest byte of beat 2 is never reachable (off<=3, size<=8).
  assign unused_top = ^buf_i[95:88];

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_byte
      assign win[8*gi +: 8] = buf_i[8*gi + 8*off_i +: 8];
    end
  endgenerate

  // Truncate the shifted window to the access size and extend.
  always_comb begin
    result_o = '0;
    case (load_funct3_t'(funct3_i))
      F3_LB:   result_o = {{(XLEN-8){win[7]}}, win[7:0]};
      F3_LH:   result_o = {{(XLEN-16){win[15]}}, win[15:0]};
      F3_LW:   result_o = {{(XLEN-32){win[31]}}, win[31:0]};
      F3_LD:   result_o = win[XLEN-1:0];
      F3_LBU:  result_o = {{(XLEN-8){1'b0}}, win[7:0]};
      F3_LHU:  result_o = {{(XLEN-16){1'b0}}, win[15:0]};
      F3_LWU:  result_o = {{(XLEN-32){1'b0}}, win[31:0]};
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/load_unit.sv
// Load memory-access stage: accepts one load, reads the covering 32-bit
// words one at a time over AXI4-Lite, and returns the extended result.
module load_unit
  import load_pkg::*;
#(
  parameter int ADDR_WIDTH = XLEN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [XLEN-1:0]       req_addr,
  input  logic [2:0]            req_funct3,
  input  logic [4:0]            req_rd,
  output logic                  arvalid,
  input  logic                  arready,
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic [2:0]            arprot,
  input  logic                  rvalid,
  output logic                  rready,
  input  logic [31:0]           rdata,
  input  logic [1:0]            rresp,
  output logic                  wb_valid,
  output logic [4:0]            wb_rd,
  output logic [XLEN-1:0]       wb_data,
  output logic                  wb_fault
);

  load_state_t           state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  load_funct3_t          funct3_q, funct3_d;
  logic [4:0]            rd_q, rd_d;
  logic [95:0]           buf_q, buf_d;
  logic [1:0]            beat_q, beat_d;
  logic [1:0]            last_q, last_d;
  logic                  fault_q, fault_d;

  logic [ADDR_WIDTH-1:0] beat_addr;
  logic [XLEN-1:0]       result;

  // Word address of the current beat; wraps at the top of the address space.
  assign beat_addr = {addr_q[ADDR_WIDTH-1:2], 2'b00} + ADDR_WIDTH'({beat_q, 2'b00});

  load_extract u_extract (
    .buf_i    (buf_q),
    .off_i    (addr_q[1:0]),
    .funct3_i (funct3_q),
    .result_o (result)
  );

  // Outputs are decoded from state and forced quiet while reset is held.
  assign req_ready = !rst && (state_q == IDLE);
  assign arvalid   = !rst && (state_q == ADDR);
  assign araddr    = arvalid ? beat_addr : '0;
  assign arprot    = 3'b000;
  assign rready    = !rst && (state_q == DATA);
  assign wb_valid  = !rst && (state_q == DONE);
  assign wb_fault  = wb_valid && fault_q;
  assign wb_rd     = wb_valid ? rd_q : 5'd0;
  assign wb_data   = (wb_valid && !fault_q) ? result : '0;

  // Next-state logic: latch the request, then one AR/R pair per beat.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    funct3_d = funct3_q;
    rd_d     = rd_q;
    buf_d    = buf_q;
    beat_d   = beat_q;
    last_d   = last_q;
    fault_d  = fault_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d   = req_addr[ADDR_WIDTH-1:0];
          funct3_d = load_funct3_t'(req_funct3);
          rd_d     = req_rd;
          buf_d    = '0;
          beat_d   = 2'd0;
          last_d   = load_last_beat(req_addr[1:0], req_funct3);
          fault_d  = (load_funct3_t'(req_funct3) == F3_ILLEGAL);
          state_d  = fault_d ? DONE : ADDR;
        end
      end
      ADDR: begin
        if (arready) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (rvalid) begin
          case (beat_q)
            2'd0:    buf_d[31:0]  = rdata;
            2'd1:    buf_d[63:32] = rdata;
            default: buf_d[95:64] = rdata;
          endcase
          if (rresp != AXI_RESP_OKAY) begin
            fault_d = 1'b1;
            state_d = DONE;
          end else if (beat_q == last_q) begin
            state_d = DONE;
          end else begin
            beat_d  = beat_q + 2'd1;
            state_d = ADDR;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and request registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      funct3_q <= F3_LB;
      rd_q     <= 5'd0;
      buf_q    <= '0;
      beat_q   <= 2'd0;
      last_q   <= 2'd0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      funct3_q <= funct3_d;
      rd_q     <= rd_d;
      buf_q    <= buf_d;
      beat_q   <= beat_d;
      last_q   <= last_d;
      fault_q  <= fault_d;
    end
  end

endmodule
